// File: rtl/jk_counter_sequencer.sv
// Sequencer for an external JK-flip-flop counter: optional preset, then a
// programmed number of up/down count edges, with wrap and done pulses.
module jk_counter_sequencer #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [CNT_W-1:0] run_len,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic             dir_r;
    logic [WIDTH-1:0] ld_r;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH:0]   up_p;
    logic [WIDTH:0]   dn_p;
    logic             at_end;

    // Prefix ANDs of q_in / ~q_in: bit i toggles when all lower bits are 1 (up) or 0 (down).
    assign up_p[0] = 1'b1;
    assign dn_p[0] = 1'b1;
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        assign up_p[i+1] = up_p[i] & q_in[i];
        assign dn_p[i+1] = dn_p[i] & ~q_in[i];
        assign toggle[i] = dir_r ? dn_p[i] : up_p[i];
    end

    // Full chain means this edge rolls the counter over.
    assign at_end = dir_r ? dn_p[WIDTH] : up_p[WIDTH];

    always_comb begin
        j_out = '0;
        k_out = '0;
        case (state)
            LOAD: begin
                j_out = ld_r;
                k_out = ~ld_r;
            end
            RUN: begin
                j_out = toggle;
                k_out = toggle;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dir_r      <= 1'b0;
            ld_r       <= '0;
            steps_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            busy <= 1'b0;
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        dir_r      <= dir;
                        ld_r       <= load_val;
                        steps_left <= run_len;
                        if (load_en) begin
                            state <= LOAD;
                            busy  <= 1'b1;
                        end else if (run_len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (steps_left != '0) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                RUN: begin
                    // The step on an aborting edge still happens, so wrap is still reported.
                    steps_left <= steps_left - 1'b1;
                    wrap       <= at_end;
                    if (stop) begin
                        state <= IDLE;
                    end else if (steps_left == CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// Bench: JK counter model driven by the DUT, arithmetic reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_jk_counter_sequencer;
    localparam int WIDTH = 2;
    localparam int CNT_W = 8;
    localparam int MAXQ  = (1 << WIDTH) - 1;

    logic             clk = 0;
    logic             reset = 0;
    logic             start = 0, stop = 0, dir = 0, load_en = 0;
    logic [WIDTH-1:0] load_val = '0;
    logic [CNT_W-1:0] run_len = '0;
    logic [WIDTH-1:0] q_cnt = '0;
    logic [WIDTH-1:0] j_out, k_out;
    logic             busy, done, wrap;
    logic [CNT_W-1:0] steps_left;

    int checks = 0;
    int errors = 0;

    jk_counter_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
        .load_en(load_en), .load_val(load_val), .run_len(run_len), .q_in(q_cnt),
        .j_out(j_out), .k_out(k_out), .busy(busy), .done(done), .wrap(wrap),
        .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    // The external JK counter; untouched by reset.
    always @(posedge clk) q_cnt <= (j_out & ~q_cnt) | (~k_out & q_cnt);

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 preset, 2 counting, 3 finished.
    int m_phase = 0, m_q = 0, m_ld = 0, m_steps = 0;
    bit m_dir = 0, m_done = 0, m_wrap = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_steps = 0; m_done = 0; m_wrap = 0; m_dir = 0;
        end else begin
            m_wrap = 0;
            case (m_phase)
                0: if (start && !stop) begin
                    m_dir = dir; m_ld = int'(load_val); m_steps = int'(run_len);
                    m_phase = load_en ? 1 : (run_len != 0 ? 2 : 3);
                end
                1: begin
                    m_q = m_ld;
                    m_phase = stop ? 0 : (m_steps != 0 ? 2 : 3);
                end
                2: begin
                    m_wrap = m_dir ? (m_q == 0) : (m_q == MAXQ);
                    m_q = (m_q + (m_dir ? MAXQ : 1)) & MAXQ;
                    m_steps--;
                    m_phase = stop ? 0 : (m_steps == 0 ? 3 : 2);
                end
                default: m_phase = 0;
            endcase
            m_done = (m_phase == 3);
        end
    end

    always @(negedge clk) if (reset) begin
        chk("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
        chk("done", int'(done), int'(m_done));
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("steps_left", int'(steps_left), m_steps);
        chk("q", int'(q_cnt), m_q);
        if (m_phase == 1) begin
            chk("j_load", int'(j_out), m_ld);
            chk("k_load", int'(k_out), (~m_ld) & MAXQ);
        end else if (m_phase != 2) begin
            chk("j_hold", int'(j_out), 0);
            chk("k_hold", int'(k_out), 0);
        end
    end

    int w_busy, w_wrap, w_done;
    int qs[32];

    task automatic watch(int n);
        w_busy = 0; w_wrap = 0; w_done = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w_busy += int'(busy); w_wrap += int'(wrap); w_done += int'(done);
            qs[i] = int'(q_cnt);
            @(posedge clk); #1;
        end
    endtask

    task automatic go(bit d, bit le, int lv, int rl);
        dir = d; load_en = le; load_val = WIDTH'(lv); run_len = CNT_W'(rl);
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;

        // Up run from 0, five steps.
        go(0, 0, 0, 5);
        watch(7);
        chk("up_q1", qs[1], 1); chk("up_q2", qs[2], 2); chk("up_q3", qs[3], 3);
        chk("up_q4", qs[4], 0); chk("up_q5", qs[5], 1);
        chk("up_busy", w_busy, 5); chk("up_wrap", w_wrap, 1); chk("up_done", w_done, 1);

        // Down run with preset 2, three steps.
        go(1, 1, 2, 3);
        watch(6);
        chk("dn_q1", qs[1], 2); chk("dn_q2", qs[2], 1); chk("dn_q3", qs[3], 0);
        chk("dn_q4", qs[4], 3);
        chk("dn_busy", w_busy, 4); chk("dn_wrap", w_wrap, 1); chk("dn_done", w_done, 1);

        // Zero length with and without preset.
        go(0, 1, 3, 0);
        watch(3);
        chk("z_load_q", qs[2], 3); chk("z_load_busy", w_busy, 1); chk("z_load_done", w_done, 1);
        go(0, 0, 0, 0);
        watch(3);
        chk("z_q", qs[2], 3); chk("z_busy", w_busy, 0); chk("z_done", w_done, 1);

        // Abort in the third RUN cycle from q=3.
        go(0, 0, 0, 10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        stop = 1; start = 1; dir = 1; run_len = 2;
        @(posedge clk); #1;
        stop = 0; start = 0;
        watch(2);
        chk("ab_busy", w_busy, 0); chk("ab_done", w_done, 0);
        chk("ab_steps", int'(steps_left), 7); chk("ab_q", qs[1], 2);
        start = 1; stop = 1;
        @(posedge clk); #1;
        start = 0; stop = 0;
        watch(2);
        chk("ss_busy", w_busy, 0); chk("ss_steps", int'(steps_left), 7);

        // Start while busy is ignored.
        go(0, 0, 0, 3);
        start = 1; dir = 1; load_en = 1; run_len = 9;
        @(posedge clk); #1;
        start = 0;
        watch(5);
        chk("sb_busy", w_busy, 2); chk("sb_done", w_done, 1);
        chk("sb_q", qs[4], 1); chk("sb_steps", int'(steps_left), 0);

        // Asynchronous reset mid-run.
        go(0, 0, 0, 20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("rst_busy", int'(busy), 0); chk("rst_done", int'(done), 0);
        chk("rst_wrap", int'(wrap), 0); chk("rst_steps", int'(steps_left), 0);
        chk("rst_j", int'(j_out), 0); chk("rst_k", int'(k_out), 0);
        #1 reset = 1;
        @(posedge clk); #1;

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 11) == 0);
            dir      = 1'($urandom_range(0, 1));
            load_en  = 1'($urandom_range(0, 1));
            load_val = WIDTH'($urandom_range(0, MAXQ));
            run_len  = CNT_W'($urandom_range(0, 9));
            if ($urandom_range(0, 149) == 0) begin
                reset = 0;
                #2 reset = 1;
            end
            @(posedge clk); #1;
        end
        start = 0; stop = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
